alu_op_sequencer: RTL and testbench

Sequential front-end that drives the team's 3-bit-opcode combinational ALU.
- Holds a 32x32 register file.
- On a command, reads two source registers and presents them with the opcode on the ALU operand ports.
- Captures the ALU result and flags, then writes the result back to a destination register.
- Sits between the test/host controller and the ALU. It is the issuing and consuming end of the ALU's A/B/ALU_OP -> F/OF/ZF interface.

---
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer_if
//  Brief    : Operand/result bus between the sequencer and the combinational
//             3-bit-opcode ALU (A/B/ALU_OP out, F/OF/ZF back).
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_f;
  logic          alu_of;
  logic          alu_zf;

  // Sequencer side: issues operands, consumes result and flags
  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_f, alu_of, alu_zf
  );

  // ALU side: consumes operands, returns result and flags
  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_f, alu_of, alu_zf
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Brief    : Register-file front-end for the combinational ALU. A command
//             reads two sources, drives them to the ALU, captures the result
//             and flags, and writes the result back to a destination register.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  input  wire logic [2:0]    op,
  input  wire logic [AW-1:0] rs1,
  input  wire logic [AW-1:0] rs2,
  input  wire logic [AW-1:0] rd,
  input  wire logic          host_we,
  input  wire logic [AW-1:0] host_waddr,
  input  wire logic [DW-1:0] host_wdata,
  input  wire logic [AW-1:0] host_raddr,
  output logic      [DW-1:0] host_rdata,
  alu_op_sequencer_if.master alu,
  output logic               busy,
  output logic               done,
  output logic               zf_q,
  output logic               of_q
);

  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Command latched in IDLE so the host may change inputs while we run
  logic [2:0]    cmd_op_q,  cmd_op_d;
  logic [AW-1:0] cmd_rs1_q, cmd_rs1_d;
  logic [AW-1:0] cmd_rs2_q, cmd_rs2_d;
  logic [AW-1:0] cmd_rd_q,  cmd_rd_d;

  logic [DW-1:0] alu_a_q,  alu_a_d;
  logic [DW-1:0] alu_b_q,  alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;

  // Result and flags captured at the end of EXEC, committed in WB
  logic [DW-1:0] res_q, res_d;
  logic          cof_q, cof_d;
  logic          czf_q, czf_d;
  logic          zf_d,  of_d;

  logic [NREG-1:0][DW-1:0] rf_q, rf_d;

  logic [DW-1:0] rs1_val;
  logic [DW-1:0] rs2_val;

  // r0 is hard-wired to zero on every read path
  assign rs1_val    = (cmd_rs1_q == '0) ? '0 : rf_q[cmd_rs1_q];
  assign rs2_val    = (cmd_rs2_q == '0) ? '0 : rf_q[cmd_rs2_q];
  assign host_rdata = (host_raddr == '0) ? '0 : rf_q[host_raddr];

  assign alu.alu_a  = alu_a_q;
  assign alu.alu_b  = alu_b_q;
  assign alu.alu_op = alu_op_q;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_WB);

  // Next-state, datapath and register-file update
  always_comb begin
    state_d   = state_q;
    cmd_op_d  = cmd_op_q;
    cmd_rs1_d = cmd_rs1_q;
    cmd_rs2_d = cmd_rs2_q;
    cmd_rd_d  = cmd_rd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    res_d     = res_q;
    cof_d     = cof_q;
    czf_d     = czf_q;
    zf_d      = zf_q;
    of_d      = of_q;
    rf_d      = rf_q;

    case (state_q)
      S_IDLE: begin
        // Host write lands at this edge, so a same-cycle start sees it in LOAD
        if (host_we && (host_waddr != '0)) begin
          rf_d[host_waddr] = host_wdata;
        end
        if (start) begin
          cmd_op_d  = op;
          cmd_rs1_d = rs1;
          cmd_rs2_d = rs2;
          cmd_rd_d  = rd;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        alu_a_d  = rs1_val;
        alu_b_d  = rs2_val;
        alu_op_d = cmd_op_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu.alu_f;
        cof_d   = alu.alu_of;
        czf_d   = alu.alu_zf;
        state_d = S_WB;
      end
      S_WB: begin
        if (cmd_rd_q != '0) begin
          rf_d[cmd_rd_q] = res_q;
        end
        zf_d    = czf_q;
        of_d    = cof_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_op_q  <= '0;
      cmd_rs1_q <= '0;
      cmd_rs2_q <= '0;
      cmd_rd_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      res_q     <= '0;
      cof_q     <= 1'b0;
      czf_q     <= 1'b0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
      rf_q      <= '0;
    end else begin
      state_q   <= state_d;
      cmd_op_q  <= cmd_op_d;
      cmd_rs1_q <= cmd_rs1_d;
      cmd_rs2_q <= cmd_rs2_d;
      cmd_rd_q  <= cmd_rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      res_q     <= res_d;
      cof_q     <= cof_d;
      czf_q     <= czf_d;
      zf_q      <= zf_d;
      of_q      <= of_d;
      rf_q      <= rf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Brief    : Scoreboard bench for alu_op_sequencer with a behavioural ALU and
//             a register-file reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        host_we = 1'b0;
  logic [4:0]  host_waddr = '0;
  logic [31:0] host_wdata = '0;
  logic [4:0]  host_raddr;
  logic [31:0] host_rdata;
  logic        busy, done, zf_q, of_q;

  logic [4:0]  stim_raddr = '0;
  logic [4:0]  mon_raddr = '0;
  logic        mon_active = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  assign host_raddr = mon_active ? mon_raddr : stim_raddr;

  alu_op_sequencer_if #(.DW(32)) alu_if ();

  alu_op_sequencer #(.DW(32), .AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .alu        (alu_if.master),
    .busy       (busy),
    .done       (done),
    .zf_q       (zf_q),
    .of_q       (of_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {of, zf, f}
  function automatic logic [33:0] alu_ref(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] f;
    logic        ovf;
    ovf = 1'b0;
    case (o)
      3'b000: f = a & b;
      3'b001: f = a | b;
      3'b010: f = a ^ b;
      3'b011: f = ~(a | b);
      3'b100: begin f = a + b; ovf = (a[31] == b[31]) && (f[31] != a[31]); end
      3'b101: begin f = a - b; ovf = (a[31] != b[31]) && (f[31] != a[31]); end
      3'b110: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = a << b[4:0];
    endcase
    return {ovf, (f == 32'd0), f};
  endfunction

  logic [33:0] alu_out;
  always_comb begin
    alu_out        = alu_ref(alu_if.alu_op, alu_if.alu_a, alu_if.alu_b);
    alu_if.alu_f   = alu_out[31:0];
    alu_if.alu_zf  = alu_out[32];
    alu_if.alu_of  = alu_out[33];
  end

  // Reference model: register contents and expected command outcomes
  logic [31:0] model_rf [32];

  typedef struct {
    logic [31:0] a, b, f;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        zf, ovf;
    int          issue;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
  endtask

  task automatic push_cmd(input logic [2:0] o, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input int issue);
    exp_t e;
    logic [33:0] r;
    e.a = model_rf[s1];
    e.b = model_rf[s2];
    r = alu_ref(o, e.a, e.b);
    e.f = r[31:0];
    e.zf = r[32];
    e.ovf = r[33];
    e.op = o;
    e.rd = d;
    e.issue = issue;
    if (d != 5'd0) model_rf[d] = e.f;
    q.push_back(e);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    if (a != 5'd0) model_rf[a] = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input bit hw, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = s1; rs2 = s2; rd = d;
    host_we = hw; host_waddr = wa; host_wdata = wd;
    if (hw && wa != 5'd0) model_rf[wa] = wd;
    push_cmd(o, s1, s2, d, cyc + 1);
    @(negedge clk);
    start = 1'b0; host_we = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (!busy && !mon_active && q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: command did not complete, %0d outstanding", q.size());
      q.delete();
    end
  endtask

  task automatic rd_chk(input logic [4:0] a, input string nm);
    stim_raddr = a;
    #1;
    chk(nm, host_rdata, model_rf[a]);
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: done=1 with no command outstanding (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          // WB occupies the third cycle after the start edge: two edges later
          chk("done_latency", cyc - e.issue, 32'd2);
          chk("alu_a", alu_if.alu_a, e.a);
          chk("alu_b", alu_if.alu_b, e.b);
          chk("alu_op", {29'd0, alu_if.alu_op}, {29'd0, e.op});
          mon_raddr  = e.rd;
          mon_active = 1'b1;
          @(negedge clk);
          chk("wb_rdata", host_rdata, (e.rd == 5'd0) ? 32'd0 : e.f);
          chk("zf_q", {31'd0, zf_q}, {31'd0, e.zf});
          chk("of_q", {31'd0, of_q}, {31'd0, e.ovf});
          chk("done_one_cycle", {31'd0, done}, 32'd0);
          mon_active = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [2:0]  ro;
    logic [4:0]  ra, rb, rc, wa;
    logic [31:0] wd;
    bit          hw;

    model_clear();
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_zf", {31'd0, zf_q}, 32'd0);
    chk("rst_of", {31'd0, of_q}, 32'd0);
    chk("rst_alu_a", alu_if.alu_a, 32'd0);
    chk("rst_alu_b", alu_if.alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_if.alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: add, sub-to-zero, signed overflow
    host_write(5'd1, 32'd5);
    host_write(5'd2, 32'd3);
    issue(3'b100, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0);
    wait_idle();
    stim_raddr = 5'd3; #1;
    chk("add_r3", host_rdata, 32'd8);
    chk("add_alu_a", alu_if.alu_a, 32'd5);

    host_write(5'd1, 32'h0000_0007);
    issue(3'b101, 5'd1, 5'd1, 5'd4, 1'b0, 5'd0, 32'd0);
    wait_idle();
    stim_raddr = 5'd4; #1;
    chk("sub_r4", host_rdata, 32'd0);
    chk("sub_zf", {31'd0, zf_q}, 32'd1);

    host_write(5'd5, 32'h7FFF_FFFF);
    host_write(5'd6, 32'd1);
    issue(3'b100, 5'd5, 5'd6, 5'd7, 1'b0, 5'd0, 32'd0);
    wait_idle();
    stim_raddr = 5'd7; #1;
    chk("ovf_r7", host_rdata, 32'h8000_0000);
    chk("ovf_of", {31'd0, of_q}, 32'd1);

    // Overlap: start and host write during LOAD are ignored
    host_write(5'd9, 32'h0000_AAAA);
    @(negedge clk);
    start = 1'b1; op = 3'b001; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd10;
    push_cmd(3'b001, 5'd1, 5'd2, 5'd10, cyc + 1);
    @(negedge clk);
    op = 3'b000; rs1 = 5'd3; rs2 = 5'd3; rd = 5'd11;
    host_we = 1'b1; host_waddr = 5'd9; host_wdata = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0; host_we = 1'b0;
    wait_idle();
    stim_raddr = 5'd9; #1;
    chk("busy_hostwe_ignored", host_rdata, 32'h0000_AAAA);
    rd_chk(5'd11, "busy_start_ignored");

    // rd=0: completes, r0 unchanged; host write to r0 discarded
    issue(3'b000, 5'd1, 5'd2, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    wait_idle();
    rd_chk(5'd0, "r0_zero");

    // Same-cycle host write and start, operands aliasing destination
    issue(3'b100, 5'd12, 5'd12, 5'd12, 1'b1, 5'd12, 32'h1111_2222);
    wait_idle();

    // Start held high: re-sampled in IDLE four cycles later
    host_write(5'd13, 32'd1);
    host_write(5'd14, 32'd2);
    @(negedge clk);
    start = 1'b1; op = 3'b100; rs1 = 5'd13; rs2 = 5'd14; rd = 5'd13;
    push_cmd(3'b100, 5'd13, 5'd14, 5'd13, cyc + 1);
    push_cmd(3'b100, 5'd13, 5'd14, 5'd13, cyc + 5);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_idle();
    rd_chk(5'd13, "held_start_r13");

    // Reset in EXEC aborts the command and clears everything
    host_write(5'd8, 32'h0000_1234);
    @(negedge clk);
    start = 1'b1; op = 3'b010; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_alu_a", alu_if.alu_a, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim_raddr = 5'd8; #1;
    chk("abort_r8", host_rdata, 32'd0);
    repeat (3) @(negedge clk);
    host_write(5'd1, 32'h0000_00F0);
    host_write(5'd2, 32'h0000_000F);
    issue(3'b010, 5'd1, 5'd2, 5'd8, 1'b0, 5'd0, 32'd0);
    wait_idle();
    rd_chk(5'd8, "post_reset_r8");

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1)
        host_write(5'($urandom_range(31, 0)), $urandom());
      ro = 3'($urandom_range(7, 0));
      ra = 5'($urandom_range(31, 0));
      rb = 5'($urandom_range(31, 0));
      rc = 5'($urandom_range(31, 0));
      wa = 5'($urandom_range(31, 0));
      wd = ($urandom_range(3, 0) == 0) ? 32'h7FFF_FFFF : $urandom();
      hw = ($urandom_range(3, 0) == 0);
      issue(ro, ra, rb, rc, hw, wa, wd);
      wait_idle();
      if ((n % 5) == 0) rd_chk(5'($urandom_range(31, 0)), "rand_readback");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
